// File: rtl/vco_phase_scheduler.sv
// rtl/vco_phase_scheduler.sv - V/Oct LUT lookup, phase accumulate and four-phase wavetable read sequencer
module vco_phase_scheduler #(
  parameter int W              = 16,
  parameter int V_OCT_LUT_SIZE = 512,
  parameter int WAVETABLE_SIZE = 256,
  parameter int FDIV           = 0,
  localparam int LAW           = $clog2(V_OCT_LUT_SIZE),
  localparam int WAW           = $clog2(WAVETABLE_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  output logic [LAW-1:0]      lut_addr,
  input  logic [W-1:0]        lut_data,
  output logic [WAW-1:0]      wt_addr,
  input  logic [W-1:0]        wt_data,
  output logic signed [W-1:0] sample_out0,
  output logic signed [W-1:0] sample_out1,
  output logic signed [W-1:0] sample_out2,
  output logic signed [W-1:0] sample_out3,
  output logic                busy,
  output logic                done,
  output logic [7:0]          overrun_count
);

  localparam int             PH_LSB = 10 + FDIV;
  localparam logic [WAW-1:0] QTR    = WAW'(WAVETABLE_SIZE / 4);

  typedef enum logic [2:0] {
    S_IDLE, S_LUT_WAIT, S_ACC, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP
  } state_t;

  state_t              r_state;
  logic                r_sample_clk_prev;
  logic [31:0]         r_phase_acc;
  logic [LAW-1:0]      r_lut_addr;
  logic [WAW-1:0]      r_wt_addr;
  logic signed [W-1:0] r_shadow0, r_shadow1, r_shadow2;
  logic signed [W-1:0] r_out0, r_out1, r_out2, r_out3;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_overrun;

  logic                w_edge;
  logic signed [W-1:0] w_shift;
  logic [LAW-1:0]      w_idx;
  logic [31:0]         w_acc_next;
  logic [WAW-1:0]      w_base_next;
  logic                w_unused_shift;

  assign w_edge      = sample_clk & ~r_sample_clk_prev;
  assign w_shift     = sample_in0 >>> 6;
  // Negative pitch voltages all map to the bottom LUT entry.
  assign w_idx       = w_shift[W-1] ? '0 : w_shift[LAW-1:0];
  assign w_acc_next  = r_phase_acc + {{(32-W){1'b0}}, lut_data};
  // Base index is taken from the accumulator value being written, so RD0 can present it immediately.
  assign w_base_next = w_acc_next[PH_LSB+WAW-1:PH_LSB];
  assign w_unused_shift = ^w_shift[W-2:LAW];

  assign lut_addr      = r_lut_addr;
  assign wt_addr       = r_wt_addr;
  assign sample_out0   = r_out0;
  assign sample_out1   = r_out1;
  assign sample_out2   = r_out2;
  assign sample_out3   = r_out3;
  assign busy          = r_busy;
  assign done          = r_done;
  assign overrun_count = r_overrun;

  // Update sequencer: edge detect, overrun counting, LUT/accumulate/read pipeline and atomic commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_sample_clk_prev <= 1'b0;
      r_phase_acc       <= '0;
      r_lut_addr        <= '0;
      r_wt_addr         <= '0;
      r_shadow0         <= '0;
      r_shadow1         <= '0;
      r_shadow2         <= '0;
      r_out0            <= '0;
      r_out1            <= '0;
      r_out2            <= '0;
      r_out3            <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_overrun         <= '0;
    end else begin
      r_sample_clk_prev <= sample_clk;
      r_done            <= 1'b0;
      if (w_edge && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_lut_addr <= w_idx;
            r_busy     <= 1'b1;
            r_state    <= S_LUT_WAIT;
          end
        end
        S_LUT_WAIT: r_state <= S_ACC;
        S_ACC: begin
          r_phase_acc <= w_acc_next;
          r_wt_addr   <= w_base_next;
          r_state     <= S_RD0;
        end
        S_RD0: begin
          r_wt_addr <= r_wt_addr + QTR;
          r_state   <= S_RD1;
        end
        S_RD1: begin
          r_wt_addr <= r_wt_addr + QTR;
          r_shadow0 <= wt_data;
          r_state   <= S_RD2;
        end
        S_RD2: begin
          r_wt_addr <= r_wt_addr + QTR;
          r_shadow1 <= wt_data;
          r_state   <= S_RD3;
        end
        S_RD3: begin
          r_shadow2 <= wt_data;
          r_state   <= S_CAP;
        end
        S_CAP: begin
          // The 270-degree sample arrives now, so it goes straight to its output alongside the shadows.
          r_out0  <= r_shadow0;
          r_out1  <= r_shadow1;
          r_out2  <= r_shadow2;
          r_out3  <= wt_data;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_phase_scheduler.sv
// tb/tb_vco_phase_scheduler.sv - directed self-checking bench for vco_phase_scheduler
module tb_vco_phase_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               sample_clk, sample_clk2;
  logic signed [15:0] sample_in0;
  logic [8:0]         lut_addr, lut_addr2;
  logic [15:0]        lut_data, lut_data2;
  logic [7:0]         wt_addr, wt_addr2;
  logic [15:0]        wt_data, wt_data2;
  logic signed [15:0] so0, so1, so2, so3;
  logic signed [15:0] to0, to1, to2, to3;
  logic               busy, done, busy2, done2;
  logic [7:0]         ovr, ovr2;
  logic [15:0]        lut_ret;

  int checks   = 0;
  int failures = 0;
  int done_cnt  = 0;
  int done_cnt2 = 0;

  vco_phase_scheduler #(.W(16), .V_OCT_LUT_SIZE(512), .WAVETABLE_SIZE(256), .FDIV(0)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .sample_in0(sample_in0),
    .lut_addr(lut_addr), .lut_data(lut_data), .wt_addr(wt_addr), .wt_data(wt_data),
    .sample_out0(so0), .sample_out1(so1), .sample_out2(so2), .sample_out3(so3),
    .busy(busy), .done(done), .overrun_count(ovr)
  );

  vco_phase_scheduler #(.W(16), .V_OCT_LUT_SIZE(512), .WAVETABLE_SIZE(256), .FDIV(2)) dut2 (
    .clk(clk), .rst(rst), .sample_clk(sample_clk2), .sample_in0(sample_in0),
    .lut_addr(lut_addr2), .lut_data(lut_data2), .wt_addr(wt_addr2), .wt_data(wt_data2),
    .sample_out0(to0), .sample_out1(to1), .sample_out2(to2), .sample_out3(to3),
    .busy(busy2), .done(done2), .overrun_count(ovr2)
  );

  function automatic logic [15:0] wt_val(input logic [7:0] a);
    return 16'h1000 + {8'h00, a} * 16'd3;
  endfunction

  // Synchronous-read memory models
  always @(posedge clk) begin
    lut_data  <= lut_ret;
    lut_data2 <= lut_ret;
    wt_data   <= wt_val(wt_addr);
    wt_data2  <= wt_val(wt_addr2);
  end

  always @(negedge clk) begin
    if (done)  done_cnt  = done_cnt + 1;
    if (done2) done_cnt2 = done_cnt2 + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_clk = 1'b0;
    sample_clk2 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic strobe(input bit sel, input logic [15:0] val);
    sample_in0 = val;
    if (sel) sample_clk2 = 1'b1; else sample_clk = 1'b1;
    tick(1);
    sample_clk = 1'b0;
    sample_clk2 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sel ? done2 : done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b1; sample_clk = 1'b0; sample_clk2 = 1'b0; sample_in0 = '0; lut_ret = '0;
    tick(3);
    rst = 1'b0;
    d0 = done_cnt;
    tick(20);
    checks++;
    if ({so0, so1, so2, so3} !== 64'h0) begin
      failures++; $display("FAIL reset_outputs got %h exp 0", {so0, so1, so2, so3});
    end
    checks++;
    if ({busy, done, ovr, lut_addr, wt_addr} !== 27'h0) begin
      failures++; $display("FAIL reset_ctrl got busy=%b done=%b ovr=%0d lut=%0d wt=%0d exp all 0", busy, done, ovr, lut_addr, wt_addr);
    end
    checks++;
    if (done_cnt != d0) begin
      failures++; $display("FAIL reset_no_done got %0d pulses exp 0", done_cnt - d0);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  ea[4];
    logic [15:0] eo[4];
    int d0;
    bit ok;
    ea = '{8'd1, 8'd65, 8'd129, 8'd193};
    eo = '{16'h1003, 16'h10C3, 16'h1183, 16'h1243};
    lut_ret = 16'h0400;
    d0 = done_cnt;
    strobe(0, 16'h0C00);
    checks++;
    if (lut_addr !== 9'd48 || busy !== 1'b1) begin
      failures++; $display("FAIL basic_lut_addr got %0d busy=%b exp 48 busy=1", lut_addr, busy);
    end
    tick(2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wt_addr !== ea[k]) begin
        failures++; $display("FAIL basic_wt_addr%0d got %0d exp %0d", k, wt_addr, ea[k]);
      end
      tick(1);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || {so0, so1, so2, so3} !== 64'h0) begin
      failures++; $display("FAIL basic_t7 got done=%b busy=%b out=%h exp done=0 busy=1 out=0", done, busy, {so0, so1, so2, so3});
    end
    tick(1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_t8_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    checks++;
    if ({so0, so1, so2, so3} !== {eo[0], eo[1], eo[2], eo[3]}) begin
      failures++; $display("FAIL basic_outputs got %h exp %h", {so0, so1, so2, so3}, {eo[0], eo[1], eo[2], eo[3]});
    end
    tick(1);
    checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL basic_done_pulse got done=%b count=%0d exp done=0 count=1", done, done_cnt - d0);
    end
    ok = 1'b1;
  endtask

  task automatic test_lut_clamp();
    logic [15:0] vin[3];
    logic [8:0]  eaddr[3];
    bit ok;
    vin   = '{16'h8000, 16'h7FFF, 16'hFFFF};
    eaddr = '{9'd0, 9'd511, 9'd0};
    for (int i = 0; i < 3; i++) begin
      strobe(0, vin[i]);
      checks++;
      if (lut_addr !== eaddr[i]) begin
        failures++; $display("FAIL clamp_lut_addr in=%h got %0d exp %0d", vin[i], lut_addr, eaddr[i]);
      end
      wait_done(0, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL clamp_done_timeout got no done exp done within 20 cycles");
      end
    end
  endtask

  task automatic test_wrap(input bit sel);
    logic [7:0]  ea[4];
    logic [15:0] eo[4];
    logic [7:0]  wa;
    int n;
    bit ok;
    ea = '{8'd200, 8'd8, 8'd72, 8'd136};
    eo = '{16'h1258, 16'h1018, 16'h10D8, 16'h1198};
    do_reset();
    lut_ret = 16'hC800;
    n = sel ? 16 : 4;
    for (int i = 0; i < n - 1; i++) begin
      strobe(sel, 16'h0000);
      wait_done(sel, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL wrap_done_timeout fdiv_dut=%0d step %0d got no done exp done", sel, i);
      end
    end
    strobe(sel, 16'h0000);
    tick(2);
    for (int k = 0; k < 4; k++) begin
      wa = sel ? wt_addr2 : wt_addr;
      checks++;
      if (wa !== ea[k]) begin
        failures++; $display("FAIL wrap_wt_addr%0d fdiv_dut=%0d got %0d exp %0d", k, sel, wa, ea[k]);
      end
      tick(1);
    end
    tick(1);
    checks++;
    if (sel ? ({to0, to1, to2, to3} !== {eo[0], eo[1], eo[2], eo[3]})
            : ({so0, so1, so2, so3} !== {eo[0], eo[1], eo[2], eo[3]})) begin
      failures++; $display("FAIL wrap_outputs fdiv_dut=%0d got %h exp %h", sel,
                           sel ? {to0, to1, to2, to3} : {so0, so1, so2, so3}, {eo[0], eo[1], eo[2], eo[3]});
    end
  endtask

  task automatic test_overrun();
    int d0;
    bit ok;
    do_reset();
    lut_ret = 16'h0400;
    d0 = done_cnt;
    strobe(0, 16'h0C00);
    tick(3);
    sample_clk = 1'b1;
    tick(1);
    sample_clk = 1'b0;
    checks++;
    if (ovr !== 8'd1) begin
      failures++; $display("FAIL overrun_one got %0d exp 1", ovr);
    end
    wait_done(0, ok);
    checks++;
    if (!ok || so0 !== 16'sh1003) begin
      failures++; $display("FAIL overrun_first_commit got done=%b out0=%h exp done=1 out0=1003", ok, so0);
    end
    // Edge in the done cycle must be accepted
    strobe(0, 16'h0C00);
    checks++;
    if (busy !== 1'b1 || ovr !== 8'd1) begin
      failures++; $display("FAIL back_to_back_accept got busy=%b ovr=%0d exp busy=1 ovr=1", busy, ovr);
    end
    tick(2);
    checks++;
    if (wt_addr !== 8'd2) begin
      failures++; $display("FAIL overrun_phase_once got base %0d exp 2", wt_addr);
    end
    wait_done(0, ok);
    tick(2);
    checks++;
    if (done_cnt - d0 != 2) begin
      failures++; $display("FAIL overrun_done_count got %0d exp 2", done_cnt - d0);
    end
    for (int i = 0; i < 1000; i++) begin
      sample_clk = ~sample_clk;
      tick(1);
    end
    sample_clk = 1'b0;
    tick(12);
    checks++;
    if (ovr !== 8'd255) begin
      failures++; $display("FAIL overrun_saturate got %0d exp 255", ovr);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok;
    do_reset();
    lut_ret = 16'h0400;
    d0 = done_cnt;
    strobe(0, 16'h0C00);
    tick(4);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || lut_addr !== 9'd0 || wt_addr !== 8'd0) begin
      failures++; $display("FAIL midrst_async got busy=%b lut=%0d wt=%0d exp 0 0 0", busy, lut_addr, wt_addr);
    end
    tick(2);
    rst = 1'b0;
    tick(12);
    checks++;
    if (done_cnt != d0 || {so0, so1, so2, so3} !== 64'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_no_commit got dones=%0d out=%h busy=%b exp 0 0 0", done_cnt - d0, {so0, so1, so2, so3}, busy);
    end
    strobe(0, 16'h0C00);
    tick(2);
    checks++;
    if (wt_addr !== 8'd1) begin
      failures++; $display("FAIL midrst_first_update got base %0d exp 1", wt_addr);
    end
    wait_done(0, ok);
    checks++;
    if (!ok || so1 !== 16'sh10C3 || so3 !== 16'sh1243) begin
      failures++; $display("FAIL midrst_outputs got done=%b out1=%h out3=%h exp 1 10c3 1243", ok, so1, so3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lut_clamp();
    test_wrap(0);
    test_wrap(1);
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
